// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/subtract, CHUNK bits per clock, LSB first.
// Handshake: start accepted in IDLE, busy during RUN, one-cycle done pulse.
// Optional feature macro: SEQ_ADDSUB_SATURATE_EN (signed saturation of sum on overflow).
module seq_addsub #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_addsub: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] shifted;
  logic             cin_msb;

  // Chunk adder and result shift: new chunk enters at the MSB end.
  // Carry into the chunk's top bit is recovered as a^b^s of that bit.
  always_comb begin
    csum      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    chunk_ext = WIDTH'(csum[CHUNK-1:0]);
    shifted   = (res_q >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
    cin_msb   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1];
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = csum[CHUNK];
        res_d   = shifted;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          sum_d   = shifted;
          cout_d  = csum[CHUNK];
          ovf_d   = cin_msb ^ csum[CHUNK];
`ifdef SEQ_ADDSUB_SATURATE_EN
          // On the last chunk a_q[CHUNK-1] is the sign of operand a.
          if (cin_msb ^ csum[CHUNK]) begin
            sum_d = a_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output decode.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule
